// File: rtl/line_buffer_sched_if.sv
// Sink/buffer/source signal bundle for the deinterlacer line buffer scheduler.
// master = scheduler side, slave = sink, FIFO and source side.
interface line_buffer_sched_if;
    logic        din_valid;
    logic        din_startofpacket;
    logic        din_endofpacket;
    logic        din_ready;
    logic        wr_req0;
    logic        wr_req1;
    logic        full0;
    logic        full1;
    logic        empty_en0;
    logic        empty_en1;
    logic        pair_ready;
    logic        rd_pix;
    logic        rd_req0;
    logic        rd_req1;
    logic        pair_done;
    logic [15:0] err_count;

    modport master (
        input  din_valid, din_startofpacket, din_endofpacket,
        input  full0, full1, rd_pix,
        output din_ready, wr_req0, wr_req1, empty_en0, empty_en1,
        output pair_ready, rd_req0, rd_req1, pair_done, err_count
    );

    modport slave (
        output din_valid, din_startofpacket, din_endofpacket,
        output full0, full1, rd_pix,
        input  din_ready, wr_req0, wr_req1, empty_en0, empty_en1,
        input  pair_ready, rd_req0, rd_req1, pair_done, err_count
    );
endinterface

// File: rtl/line_buffer_sched.sv
// Ping-pong write / paired read scheduler for two 1-line FIFO buffers.
// Optional dropped-line counter: define LINE_BUFFER_SCHED_ERR_CNT_EN.
module line_buffer_sched #(
    parameter int LINE_WIDTH = 720,
    parameter int CNT_W      = $clog2(LINE_WIDTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    line_buffer_sched_if.master bus
);
    typedef enum logic [1:0] {W_IDLE, W_FILL0, W_FILL1, W_HOLD} wstate_t;
    typedef enum logic {R_IDLE, R_READ} rstate_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WIDTH - 1);

    wstate_t          r_wstate, w_wstate_nxt;
    rstate_t          r_rstate, w_rstate_nxt;
    logic [CNT_W-1:0] r_wr_cnt, w_wr_cnt_nxt;
    logic [CNT_W-1:0] r_rd_cnt, w_rd_cnt_nxt;
    logic             r_eop_pair, w_eop_pair_nxt;

    logic w_fill, w_full, w_first, w_last;
    logic w_restart, w_ready, w_beat, w_short, w_flush;
    logic w_rd_en, w_pair_done;

    always_comb begin
        w_fill    = (r_wstate == W_FILL0) || (r_wstate == W_FILL1);
        w_full    = (r_wstate == W_FILL1) ? bus.full1 : bus.full0;
        w_first   = (r_wstate == W_FILL0) && (r_wr_cnt == '0);
        w_last    = (r_wr_cnt == LAST);
        // SOP at the very start of buffer 0 is a legal line start,
        // anywhere else mid-pair it restarts the pair
        w_restart = w_fill && bus.din_valid && bus.din_startofpacket
                    && !w_first && !reset;
        w_ready   = 1'b0;
        unique case (r_wstate)
            W_IDLE:           w_ready = 1'b1;
            W_FILL0, W_FILL1: w_ready = !w_full && !w_restart;
            default:          w_ready = 1'b0;
        endcase
        w_ready   = w_ready && !reset;
        w_beat    = bus.din_valid && w_ready;
        w_short   = w_fill && w_beat && bus.din_endofpacket && !w_last;
        w_flush   = w_restart || w_short;
    end

    always_comb begin
        w_rd_en     = (r_rstate == R_READ) && bus.rd_pix && !reset;
        w_pair_done = w_rd_en && (r_rd_cnt == LAST);
    end

    always_comb begin
        w_wstate_nxt   = r_wstate;
        w_wr_cnt_nxt   = r_wr_cnt;
        w_eop_pair_nxt = r_eop_pair;
        unique case (r_wstate)
            W_IDLE: begin
                if (w_beat && bus.din_startofpacket) begin
                    w_wr_cnt_nxt = CNT_W'(1);
                    w_wstate_nxt = W_FILL0;
                end
            end
            W_FILL0, W_FILL1: begin
                if (w_restart) begin
                    w_wr_cnt_nxt = '0;
                    w_wstate_nxt = W_FILL0;
                end else if (w_short) begin
                    w_wr_cnt_nxt = '0;
                    w_wstate_nxt = W_IDLE;
                end else if (w_beat) begin
                    if (w_last) begin
                        w_wr_cnt_nxt = '0;
                        if (r_wstate == W_FILL0) begin
                            w_wstate_nxt = W_FILL1;
                        end else begin
                            w_wstate_nxt   = W_HOLD;
                            w_eop_pair_nxt = bus.din_endofpacket;
                        end
                    end else begin
                        w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
                    end
                end
            end
            W_HOLD: begin
                if (w_pair_done)
                    w_wstate_nxt = r_eop_pair ? W_IDLE : W_FILL0;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rd_cnt_nxt = r_rd_cnt;
        unique case (r_rstate)
            R_IDLE: begin
                if (r_wstate == W_HOLD)
                    w_rstate_nxt = R_READ;
            end
            R_READ: begin
                if (w_pair_done) begin
                    w_rd_cnt_nxt = '0;
                    w_rstate_nxt = R_IDLE;
                end else if (w_rd_en) begin
                    w_rd_cnt_nxt = r_rd_cnt + CNT_W'(1);
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wstate   <= W_IDLE;
            r_rstate   <= R_IDLE;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_eop_pair <= 1'b0;
        end else begin
            r_wstate   <= w_wstate_nxt;
            r_rstate   <= w_rstate_nxt;
            r_wr_cnt   <= w_wr_cnt_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
            r_eop_pair <= w_eop_pair_nxt;
        end
    end

    assign bus.din_ready  = w_ready;
    assign bus.wr_req0    = w_beat && !w_short &&
                            ((r_wstate == W_IDLE && bus.din_startofpacket)
                             || r_wstate == W_FILL0);
    assign bus.wr_req1    = w_beat && !w_short && (r_wstate == W_FILL1);
    assign bus.empty_en0  = w_flush;
    assign bus.empty_en1  = w_flush;
    assign bus.pair_ready = (r_wstate == W_HOLD) && !reset;
    assign bus.rd_req0    = w_rd_en;
    assign bus.rd_req1    = w_rd_en;
    assign bus.pair_done  = w_pair_done;

`ifdef LINE_BUFFER_SCHED_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clock) begin
        if (reset)
            r_err_cnt <= 16'h0000;
        else if (w_flush && r_err_cnt != 16'hFFFF)
            r_err_cnt <= r_err_cnt + 16'h0001;
    end

    assign bus.err_count = r_err_cnt;
`else
    assign bus.err_count = 16'h0000;
`endif
endmodule

// File: tb/tb_line_buffer_sched.sv
// Directed bench for line_buffer_sched with LINE_WIDTH=8.
// Inputs change #1 after posedge, outputs are checked on negedge.
module tb_line_buffer_sched;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tot = 0;
    int   n_bad = 0;

`ifdef LINE_BUFFER_SCHED_ERR_CNT_EN
    localparam int ERR_ON = 1;
`else
    localparam int ERR_ON = 0;
`endif

    always #5 clock = ~clock;

    line_buffer_sched_if bus ();

    line_buffer_sched #(.LINE_WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic setin(input logic v, input logic s,
                         input logic e, input logic p);
        bus.din_valid         = v;
        bus.din_startofpacket = s;
        bus.din_endofpacket   = e;
        bus.rd_pix            = p;
    endtask

    task automatic feed(input int n, input logic sop0, input logic eopn,
                        input int buf_sel);
        for (int i = 0; i < n; i++) begin
            setin(1'b1, sop0 && i == 0, eopn && i == n - 1, 1'b0);
            @(negedge clock);
            check("wr0", 32'(bus.wr_req0), 32'(buf_sel == 0));
            check("wr1", 32'(bus.wr_req1), 32'(buf_sel == 1));
            tick();
        end
    endtask

    initial begin
        bus.full0 = 1'b0;
        bus.full1 = 1'b0;
        setin(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        @(negedge clock);
        check("rst_rdy", 32'(bus.din_ready), 0);
        check("rst_wr0", 32'(bus.wr_req0), 0);
        check("rst_rdq", 32'(bus.rd_req0), 0);
        check("rst_pr", 32'(bus.pair_ready), 0);
        check("rst_err", 32'(bus.err_count), 0);
        tick();
        reset = 1'b0;

        // idle: non-SOP beats dropped, rd_pix ignored
        setin(1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        check("idle_rdy", 32'(bus.din_ready), 1);
        check("idle_wr0", 32'(bus.wr_req0), 0);
        check("idle_wr1", 32'(bus.wr_req1), 0);
        check("idle_rdq0", 32'(bus.rd_req0), 0);
        check("idle_rdq1", 32'(bus.rd_req1), 0);
        tick();

        feed(8, 1'b1, 1'b0, 0);
        feed(8, 1'b0, 1'b0, 1);
        setin(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("hold_pr", 32'(bus.pair_ready), 1);
        check("hold_rdy", 32'(bus.din_ready), 0);
        tick();
        setin(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        check("hold_sop_rdy", 32'(bus.din_ready), 0);
        check("hold_sop_wr0", 32'(bus.wr_req0), 0);
        tick();

        // read the pair with gaps
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < k % 3; g++) begin
                setin(1'b0, 1'b0, 1'b0, 1'b0);
                @(negedge clock);
                check("gap_rdq", 32'(bus.rd_req0), 0);
                tick();
            end
            setin(1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clock);
            check("rdq0", 32'(bus.rd_req0), 1);
            check("rdq1", 32'(bus.rd_req1), 1);
            check("pdone", 32'(bus.pair_done), 32'(k == 7));
            tick();
        end
        setin(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("post_pr", 32'(bus.pair_ready), 0);
        check("post_rdy", 32'(bus.din_ready), 1);
        tick();

        // short line: EOP at beat 5 of buffer 0
        feed(5, 1'b1, 1'b0, 0);
        setin(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        check("short_e0", 32'(bus.empty_en0), 1);
        check("short_e1", 32'(bus.empty_en1), 1);
        tick();
        setin(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("short_e0_off", 32'(bus.empty_en0), 0);
        check("short_err", 32'(bus.err_count), 32'(ERR_ON));
        tick();
        setin(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("short_idle_rdy", 32'(bus.din_ready), 1);
        check("short_idle_wr0", 32'(bus.wr_req0), 0);
        tick();

        // backpressure mid buffer 0, then restart at beat 3 of buffer 1
        feed(4, 1'b1, 1'b0, 0);
        bus.full0 = 1'b1;
        setin(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("full_rdy", 32'(bus.din_ready), 0);
        check("full_wr0", 32'(bus.wr_req0), 0);
        tick();
        bus.full0 = 1'b0;
        feed(4, 1'b0, 1'b0, 0);
        feed(3, 1'b0, 1'b0, 1);
        setin(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        check("rs_e0", 32'(bus.empty_en0), 1);
        check("rs_e1", 32'(bus.empty_en1), 1);
        check("rs_rdy", 32'(bus.din_ready), 0);
        check("rs_wr0", 32'(bus.wr_req0), 0);
        check("rs_wr1", 32'(bus.wr_req1), 0);
        tick();
        @(negedge clock);
        check("rs2_rdy", 32'(bus.din_ready), 1);
        check("rs2_wr0", 32'(bus.wr_req0), 1);
        check("rs2_e0", 32'(bus.empty_en0), 0);
        tick();
        feed(7, 1'b0, 1'b0, 0);
        feed(1, 1'b0, 1'b0, 1);
        check("rs_err", 32'(bus.err_count), 32'(2 * ERR_ON));

        // finish buffer 1 with EOP, read 4 pixels, reset mid-read
        feed(7, 1'b0, 1'b1, 1);
        setin(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            setin(1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clock);
            check("mid_rdq", 32'(bus.rd_req0), 1);
            check("mid_pdone", 32'(bus.pair_done), 0);
            tick();
        end
        reset = 1'b1;
        setin(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        @(negedge clock);
        check("mrst_rdq", 32'(bus.rd_req0), 0);
        check("mrst_pr", 32'(bus.pair_ready), 0);
        check("mrst_rdy", 32'(bus.din_ready), 0);
        check("mrst_wr0", 32'(bus.wr_req0), 0);
        check("mrst_err", 32'(bus.err_count), 0);
        tick();
        reset = 1'b0;
        setin(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        check("arst_rdq", 32'(bus.rd_req0), 0);
        check("arst_rdy", 32'(bus.din_ready), 1);
        tick();

        // full pair ending in EOP: read count restarts at 0, back to idle
        feed(8, 1'b1, 1'b0, 0);
        feed(8, 1'b0, 1'b1, 1);
        setin(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) begin
            setin(1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clock);
            check("rd2_pdone", 32'(bus.pair_done), 32'(k == 7));
            tick();
        end
        setin(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("eop_idle_rdy", 32'(bus.din_ready), 1);
        check("eop_idle_wr0", 32'(bus.wr_req0), 0);
        check("eop_idle_pr", 32'(bus.pair_ready), 0);
        tick();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/line_buffer_sched.md
Name: line_buffer_sched

Overview:
Scheduler for the two 1-line FIFO buffers of the deinterlacer datapath. It gates the AST sink handshake, steers incoming pixels ping-pong into buffer 0 then buffer 1, and declares a line pair ready once both buffers are complete. It then drives simultaneous reads of both buffers for the averaging source, and releases or flushes the buffers. It sits between the sink, the two FIFO_1K instances and the source.

Parameters:
LINE_WIDTH, 720, pixels per line; must be at most the FIFO depth of 1024
CNT_W, $clog2(LINE_WIDTH+1), width of the pixel counters

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
din_valid  in  1  AST sink valid
din_startofpacket  in  1  AST sink SOP
din_endofpacket  in  1  AST sink EOP
din_ready  out  1  AST sink ready
wr_req0  out  1  write strobe, buffer 0
wr_req1  out  1  write strobe, buffer 1
full0  in  1  buffer 0 full flag
full1  in  1  buffer 1 full flag
empty_en0  out  1  flush pulse, buffer 0
empty_en1  out  1  flush pulse, buffer 1
pair_ready  out  1  both buffers hold a complete line
rd_pix  in  1  source consumes one pixel from each buffer
rd_req0  out  1  read strobe, buffer 0
rd_req1  out  1  read strobe, buffer 1
pair_done  out  1  1-cycle pulse: last pixel of the pair read
err_count  out  16  dropped-line counter (optional feature)

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-high.
- Reset: all outputs 0. Write FSM to W_IDLE, read FSM to R_IDLE. wr_cnt=0, rd_cnt=0.
- Write FSM states: W_IDLE, W_FILL0, W_FILL1, W_HOLD.
  - din_ready=1 in W_FILL0 when full0=0, and in W_FILL1 when full1=0.
  - din_ready=1 in W_IDLE (beats are accepted and dropped until SOP).
  - din_ready=0 in W_HOLD.
- Write beat = din_valid & din_ready.
  - wr_req0/wr_req1 are combinational and asserted in the same cycle as the beat. The FIFOs take data directly from din_data.
- W_IDLE: a beat with SOP=1 writes buffer 0, sets wr_cnt=1, goes to W_FILL0. Beats without SOP are dropped.
- W_FILL0: each beat increments wr_cnt. The beat at wr_cnt==LINE_WIDTH-1 completes the line: wr_cnt=0, go to W_FILL1. W_FILL1 behaves the same way and completes to W_HOLD.
- W_HOLD: pair_ready=1 (registered, asserted in the cycle after the last write). Stays until pair_done, then goes to W_FILL0. If the pair's last line carried EOP, goes to W_IDLE instead.
- Read FSM states: R_IDLE, R_READ.
  - R_IDLE goes to R_READ when pair_ready=1.
  - In R_READ, rd_req0=rd_req1=rd_pix (combinational); rd_cnt increments per rd_pix.
  - At rd_cnt==LINE_WIDTH-1 with rd_pix: pair_done pulses, rd_cnt=0, pair_ready clears next cycle, go to R_IDLE.
- rd_pix outside R_READ is ignored; rd_req stays 0.
- Short line (EOP in W_FILL0/W_FILL1 before the line completes):
  - Both empty_en0 and empty_en1 pulse for 1 cycle.
  - wr_cnt=0, go to W_IDLE; the partial lines are dropped.
- SOP in W_FILL0/W_FILL1 (restart):
  - Both buffers flushed (empty_en pulse in the same cycle).
  - The SOP beat is not written; din_ready drops for 1 cycle.
  - Next state W_FILL0 with wr_cnt=0; the source re-sends the SOP beat.
- SOP arriving while in W_HOLD waits because din_ready=0.
- full0/full1 asserted unexpectedly during FILL: din_ready=0 (backpressure), no write, no counter change.
- Reset asserted mid-line or mid-read: immediate return to the reset state. Buffer contents are not flushed by this block; the FIFOs reset themselves.

Optional Feature:
- Macro LINE_BUFFER_SCHED_ERR_CNT_EN.
- Defined: err_count increments (saturating at 16'hFFFF) on every short-line drop and every SOP restart; cleared by reset.
- Undefined: err_count is tied to 16'h0000 and no counter logic is generated.

Test Plan:
- LINE_WIDTH=8; SOP beat then 15 beats with din_valid=1 -> wr_req0 high for beats 0-7, wr_req1 high for beats 8-15; pair_ready=1 on the cycle after beat 15; din_ready=0 afterwards.
- Pair ready; pulse rd_pix 8 times with random gaps -> rd_req0=rd_req1 exactly 8 times; pair_done on the 8th; pair_ready=0 next cycle; din_ready returns to 1.
- EOP at beat 5 of buffer 0 -> empty_en0=empty_en1=1 for 1 cycle; FSM goes to W_IDLE; err_count=1 with macro, 0 without.
- SOP at beat 3 of buffer 1 -> both flush pulses; din_ready low 1 cycle; resent SOP beat writes buffer 0 with wr_cnt=1.
- Reset asserted during R_READ at rd_cnt=4 -> next cycle all outputs 0, pair_ready=0, rd_cnt=0.
- rd_pix=1 while R_IDLE, and din beats without SOP in W_IDLE -> no rd_req, no wr_req; din_ready=1.
